// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace monitor: entry/event codes, FSM states
// and the trace entry layout at the core's native widths.
package trace_pkg;

  localparam int TR_PC_W   = 16;
  localparam int TR_ADDR_W = 16;
  localparam int TR_DATA_W = 16;

  typedef enum logic [1:0] {
    TR_REG   = 2'd0,
    TR_MEM   = 2'd1,
    TR_HALT  = 2'd2,
    TR_EVENT = 2'd3
  } tr_type_e;

  localparam int EV_TIMEOUT = 1;
  localparam int EV_HANG    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  typedef struct packed {
    tr_type_e               typ;
    logic [TR_PC_W-1:0]     pc;
    logic [TR_ADDR_W-1:0]   addr;
    logic [TR_DATA_W-1:0]   data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop trace FIFO; head entry read straight from the flop
// array, free-slot count exported so the writer can decide what to drop.
module trace_fifo #(
  parameter int W     = 50,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push0,
  input  logic [W-1:0]             din0,
  input  logic                     push1,
  input  logic [W-1:0]             din1,
  input  logic                     pop,
  output logic                     valid,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]              wptr_q, wptr_d, rptr_q, rptr_d, wptr_nx;
  logic [DEPTH-1:0][W-1:0]  mem_q, mem_d;
  logic                     full;

  always_comb begin
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    valid   = (wptr_q != rptr_q);
    // A same-cycle pop never frees room for this cycle's pushes.
    free    = full ? '0 : (AW+1)'(DEPTH) - (wptr_q - rptr_q);
    dout    = mem_q[rptr_q[AW-1:0]];
    wptr_nx = wptr_q + (AW+1)'(1);
    mem_d   = mem_q;
    if (push0) mem_d[wptr_q[AW-1:0]]  = din0;
    if (push1) mem_d[wptr_nx[AW-1:0]] = din1;
    wptr_d  = wptr_q + (AW+1)'(push0) + (AW+1)'(push1);
    rptr_d  = rptr_q + (AW+1)'(pop && valid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Execution-trace monitor: captures REG/MEM writes plus HALT/EVENT markers
// into a trace FIFO, with a cycle watchdog and a stall-hang detector.
module pipe_trace_monitor
  import trace_pkg::*;
#(
  parameter int PC_W           = 16,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int STALL_LIMIT    = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            wb_valid,
  input  logic [2:0]                      wb_rd,
  input  logic [DATA_W-1:0]               wb_data,
  input  logic [PC_W-1:0]                 wb_pc,
  input  logic                            mem_we,
  input  logic [ADDR_W-1:0]               mem_addr,
  input  logic [DATA_W-1:0]               mem_wdata,
  input  logic [PC_W-1:0]                 mem_pc,
  input  logic                            stall,
  input  logic                            halt,
  output logic                            tr_valid,
  input  logic                            tr_ready,
  output logic [2+PC_W+ADDR_W+DATA_W-1:0] tr_data,
  output logic                            done,
  output logic                            timeout,
  output logic                            hang,
  output logic [31:0]                     cycle_count,
  output logic [31:0]                     retired_count,
  output logic [15:0]                     drop_count
);
  localparam int EW = 2 + PC_W + ADDR_W + DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  mon_state_e          state_q, state_d;
  logic                run_act, halt_fire, to_fire, hang_fire;
  logic [31:0]         cycle_count_q, cycle_count_d, retired_count_q, retired_count_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic [16:0]         drop_sum;
  logic [SW-1:0]       stall_cnt_q, stall_cnt_d;
  logic                timeout_q, timeout_d, hang_q, hang_d;
  logic                hang_pend_q, hang_pend_d, end_pend_q, end_pend_d;
  logic [EW-1:0]       hang_ent_q, hang_ent_d, end_ent_q, end_ent_d;
  logic [3:0][EW-1:0]  cand;
  logic [3:0]          cand_v, taken;
  logic [1:0]          lim, n_push, n_drop;
  logic                push0, push1;
  logic [EW-1:0]       din0, din1;
  logic [AW:0]         free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (halt_fire || to_fire) state_d = ST_DRAIN;
      ST_DRAIN: if (!tr_valid && !hang_pend_q && !end_pend_q) state_d = ST_DONE;
      default:  ;
    endcase
  end

  always_comb begin
    run_act = (state_q == ST_RUN) && enable;
    done    = (state_q == ST_DONE);
  end

  always_comb begin
    halt_fire = run_act && halt;
    to_fire   = run_act && !halt && (cycle_count_q + 32'd1 == 32'(TIMEOUT_CYCLES));
    // A second hang waits at LIMIT-1 until the previous marker has left the pending slot.
    hang_fire = run_act && stall && !hang_pend_q && (stall_cnt_q == SW'(STALL_LIMIT - 1));
    cycle_count_d   = run_act ? cycle_count_q + 32'd1 : cycle_count_q;
    retired_count_d = retired_count_q + 32'(run_act && wb_valid);
    stall_cnt_d     = stall_cnt_q;
    if (run_act) begin
      if (!stall) stall_cnt_d = '0;
      else if (stall_cnt_q < SW'(STALL_LIMIT - 1) || hang_fire) stall_cnt_d = stall_cnt_q + SW'(1);
    end

    cand[0] = hang_ent_q;                                     cand_v[0] = hang_pend_q;
    cand[1] = end_ent_q;                                      cand_v[1] = end_pend_q;
    cand[2] = {TR_REG, wb_pc, ADDR_W'(wb_rd), wb_data};       cand_v[2] = run_act && wb_valid;
    cand[3] = {TR_MEM, mem_pc, mem_addr, mem_wdata};          cand_v[3] = run_act && mem_we;
    lim = (free >= (AW+1)'(2)) ? 2'd2 : free[1:0];

    n_push = '0;
    push0  = 1'b0;
    push1  = 1'b0;
    din0   = '0;
    din1   = '0;
    taken  = '0;
    for (int i = 0; i < 4; i++) begin
      if (cand_v[i] && n_push < lim) begin
        if (n_push == 2'd0) begin push0 = 1'b1; din0 = cand[i]; end
        else                begin push1 = 1'b1; din1 = cand[i]; end
        taken[i] = 1'b1;
        n_push   = n_push + 2'd1;
      end
    end

    n_drop       = 2'(cand_v[2] && !taken[2]) + 2'(cand_v[3] && !taken[3]);
    drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    hang_pend_d = (hang_pend_q && !taken[0]) || hang_fire;
    hang_ent_d  = hang_fire ? {TR_EVENT, PC_W'(0), ADDR_W'(EV_HANG), cycle_count_d[DATA_W-1:0]}
                            : hang_ent_q;
    end_pend_d  = (end_pend_q && !taken[1]) || halt_fire || to_fire;
    end_ent_d   = end_ent_q;
    if (halt_fire)    end_ent_d = {TR_HALT, wb_pc, ADDR_W'(0), DATA_W'(0)};
    else if (to_fire) end_ent_d = {TR_EVENT, PC_W'(0), ADDR_W'(EV_TIMEOUT), cycle_count_d[DATA_W-1:0]};
    timeout_d = timeout_q || to_fire;
    hang_d    = hang_q || hang_fire;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count_q   <= '0;
      retired_count_q <= '0;
      drop_count_q    <= '0;
      stall_cnt_q     <= '0;
      timeout_q       <= 1'b0;
      hang_q          <= 1'b0;
      hang_pend_q     <= 1'b0;
      end_pend_q      <= 1'b0;
      hang_ent_q      <= '0;
      end_ent_q       <= '0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
      drop_count_q    <= drop_count_d;
      stall_cnt_q     <= stall_cnt_d;
      timeout_q       <= timeout_d;
      hang_q          <= hang_d;
      hang_pend_q     <= hang_pend_d;
      end_pend_q      <= end_pend_d;
      hang_ent_q      <= hang_ent_d;
      end_ent_q       <= end_ent_d;
    end
  end

  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push0   (push0),
    .din0    (din0),
    .push1   (push1),
    .din1    (din1),
    .pop     (tr_ready),
    .valid   (tr_valid),
    .dout    (tr_data),
    .free    (free)
  );

  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;
  assign drop_count    = drop_count_q;
  assign timeout       = timeout_q;
  assign hang          = hang_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Scoreboard bench for pipe_trace_monitor: a queue-based trace model predicts
// every entry; a negedge monitor compares each popped entry in order.
module tb_pipe_trace_monitor;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int TO    = 200;
  localparam int SL    = 8;
  localparam int EW    = 50;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          enable = 0, wb_valid = 0, mem_we = 0, stall = 0, halt = 0, tr_ready = 0;
  logic [2:0]    wb_rd = '0;
  logic [15:0]   wb_data = '0, wb_pc = '0, mem_addr = '0, mem_wdata = '0, mem_pc = '0;
  logic          tr_valid, done, timeout, hang;
  logic [EW-1:0] tr_data;
  logic [31:0]   cycle_count, retired_count;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  pipe_trace_monitor #(
    .PC_W(16), .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .stall(stall), .halt(halt),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
    .done(done), .timeout(timeout), .hang(hang),
    .cycle_count(cycle_count), .retired_count(retired_count), .drop_count(drop_count)
  );

  int checks = 0, errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // Reference model: state 0 idle, 1 run, 2 drain, 3 done
  int m_state, m_occ, m_cyc, m_ret, m_drop, m_srun;
  bit m_to, m_hang;
  logic [EW-1:0] m_pend[$];

  function automatic logic [EW-1:0] mk(logic [1:0] t, logic [15:0] pc, logic [15:0] a, logic [15:0] d);
    return {t, pc, a, d};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && tr_valid && tr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL entry_unexpected got %h expected none", tr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (tr_data !== mon_e) begin
          errors++;
          $display("FAIL entry got %h expected %h", tr_data, mon_e);
        end
      end
    end
  end

  // Drive one cycle (entered and left at posedge+1) and advance the model across its edge.
  task automatic cyc(bit en, bit wbv, logic [2:0] rd, logic [15:0] wd, logic [15:0] wpc,
                     bit mwe, logic [15:0] ma, logic [15:0] md, logic [15:0] mpc,
                     bit st, bit hl, bit rdy);
    bit act, drain_ok;
    int lim, np;
    logic [EW-1:0] keep[$];
    enable = en; wb_valid = wbv; wb_rd = rd; wb_data = wd; wb_pc = wpc;
    mem_we = mwe; mem_addr = ma; mem_wdata = md; mem_pc = mpc;
    stall = st; halt = hl; tr_ready = rdy;

    act      = (m_state == 1) && en;
    drain_ok = (m_occ == 0) && (m_pend.size() == 0);
    lim = DEPTH - m_occ;
    if (lim > 2) lim = 2;
    np = 0;
    keep.delete();
    foreach (m_pend[i]) begin
      if (np < lim) begin exp_q.push_back(m_pend[i]); np++; end
      else keep.push_back(m_pend[i]);
    end
    if (act && wbv) begin
      if (np < lim) begin exp_q.push_back(mk(TR_REG, wpc, {13'd0, rd}, wd)); np++; end
      else if (m_drop < 65535) m_drop++;
    end
    if (act && mwe) begin
      if (np < lim) begin exp_q.push_back(mk(TR_MEM, mpc, ma, md)); np++; end
      else if (m_drop < 65535) m_drop++;
    end
    if (m_occ > 0 && rdy) m_occ--;
    m_occ += np;
    m_pend = keep;
    case (m_state)
      0: if (en) m_state = 1;
      1: if (act) begin
           m_cyc++;
           if (wbv) m_ret++;
           m_srun = st ? m_srun + 1 : 0;
           if (st && m_srun == SL) begin
             m_hang = 1;
             m_pend.push_back(mk(TR_EVENT, 16'd0, 16'd2, m_cyc[15:0]));
           end
           if (hl) begin
             m_pend.push_back(mk(TR_HALT, wpc, 16'd0, 16'd0));
             m_state = 2;
           end else if (m_cyc == TO) begin
             m_to = 1;
             m_pend.push_back(mk(TR_EVENT, 16'd0, 16'd1, m_cyc[15:0]));
             m_state = 2;
           end
         end
      2: if (drain_ok) m_state = 3;
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit en, bit rdy);
    cyc(en, 0, 3'd0, 16'd0, 16'd0, 0, 16'd0, 16'd0, 16'd0, 0, 0, rdy);
  endtask

  task automatic do_reset(string nm);
    reset_n = 1'b0;
    enable = 0; wb_valid = 0; mem_we = 0; stall = 0; halt = 0; tr_ready = 0;
    #1;
    chk({nm, "_tr_valid"}, tr_valid, 0);
    chk({nm, "_tr_data"}, tr_data[31:0], 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_hang"}, hang, 0);
    chk({nm, "_cycles"}, cycle_count, 0);
    chk({nm, "_retired"}, retired_count, 0);
    chk({nm, "_drops"}, drop_count, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    m_pend.delete();
    m_state = 0; m_occ = 0; m_cyc = 0; m_ret = 0; m_drop = 0; m_srun = 0;
    m_to = 0; m_hang = 0;
    reset_n = 1'b1;
  endtask

  task automatic finish_run(string nm);
    int n = 0;
    while (m_state != 3 && n < 500) begin
      idle(1, 1);
      n++;
    end
    if (m_state != 3) begin
      checks++; errors++;
      $display("FAIL %s_drain_budget got state %0d expected 3", nm, m_state);
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_timeout"}, timeout, m_to);
    chk({nm, "_hang"}, hang, m_hang);
    chk({nm, "_cycles"}, cycle_count, m_cyc);
    chk({nm, "_retired"}, retired_count, m_ret);
    chk({nm, "_drops"}, drop_count, m_drop);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
    chk({nm, "_tr_valid"}, tr_valid, 0);
  endtask

  initial begin
    int n;
    do_reset("por");

    // three register writes, streamed straight out
    idle(1, 1);
    cyc(1, 1, 3'd1, 16'h0005, 16'h0010, 0, 0, 0, 0, 0, 0, 1);
    chk("first_latency", tr_valid, 1);
    cyc(1, 1, 3'd2, 16'h000A, 16'h0011, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 3'd3, 16'h000F, 16'h0012, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 3'd0, 16'h0000, 16'h0013, 0, 0, 0, 0, 0, 1, 1);
    finish_run("three_reg");
    chk("three_reg_retired", retired_count, 3);

    // REG and MEM in one cycle, then halt
    do_reset("r2");
    idle(1, 1);
    cyc(1, 1, 3'd4, 16'h1234, 16'h0020, 1, 16'h000A, 16'h5678, 16'h0020, 0, 0, 1);
    cyc(1, 0, 3'd0, 16'h0000, 16'h0021, 0, 0, 0, 0, 0, 1, 1);
    finish_run("reg_mem");

    // FIFO overflow with consumer stalled
    do_reset("r3");
    idle(1, 0);
    for (int i = 0; i < 9; i++)
      cyc(1, 1, 3'(i), 16'(i), 16'(100 + i), 1, 16'(i), 16'(i + 50), 16'(100 + i), 0, 0, 0);
    chk("overflow_drops", drop_count, 2);
    chk("overflow_drops_model", drop_count, m_drop);
    cyc(1, 0, 3'd0, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 1, 0);
    idle(1, 0);
    chk("overflow_not_done", done, 0);
    finish_run("overflow");

    // long stall: one hang event only
    do_reset("r4");
    idle(1, 1);
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      if (i == SL - 1) chk("hang_before_limit", hang, 0);
      if (i == SL)     chk("hang_at_limit", hang, 1);
    end
    chk("hang_still_running", done, 0);
    chk("hang_cycles", cycle_count, 20);
    cyc(1, 0, 0, 0, 16'h0300, 0, 0, 0, 0, 0, 1, 1);
    finish_run("hang");

    // watchdog
    do_reset("r5");
    n = 0;
    while (m_state < 2 && n < 400) begin
      idle(1, $urandom_range(0, 1));
      n++;
    end
    chk("timeout_flag", timeout, 1);
    chk("timeout_cycles", cycle_count, TO);
    finish_run("timeout");

    // randomized runs
    for (int t = 0; t < 6; t++) begin
      do_reset("rnd");
      n = 0;
      while (m_state < 2 && n < 600) begin
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
            16'($urandom), $urandom_range(0, 9) < 4, 16'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0, n > 20 && $urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 6);
        n++;
      end
      finish_run("rnd");
    end

    // reset asserted mid-drain
    do_reset("r7");
    idle(1, 0);
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 3'(i), 16'(i + 7), 16'(i), 1, 16'(i), 16'(i), 16'(i), 0, 0, 0);
    cyc(1, 0, 0, 0, 16'h0400, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle(1, i[0]);
    chk("middrain_not_done", done, 0);
    do_reset("middrain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
